// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar master interface.
//   - default payload widths used by the interface and its buffers
//   - AXI burst type and response encodings
//   - helper to extract the source master number from a slave-side ID
package xbar_pkg;

  localparam int unsigned ID_WIDTH_DEF        = 4;
  localparam int unsigned IDS_WIDTH_DEF       = 8;
  localparam int unsigned ADDR_WIDTH_DEF      = 32;
  localparam int unsigned LEN_WIDTH_DEF       = 4;
  localparam int unsigned SIZE_WIDTH_DEF      = 3;
  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned STRB_WIDTH_DEF      = 4;
  localparam int unsigned MASTERS_DEF         = 2;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // The crossbar prepends the source master number above the master-side
  // transaction ID; shifting the ID down leaves that number in the LSBs.
  // Callers truncate the result to their master-select width.
  function automatic logic [63:0] src_master_from_id(input logic [63:0] ids,
                                                     input int unsigned id_width);
    return ids >> id_width;
  endfunction

endpackage

// File: rtl/xbar_sync_fifo.sv
// Two-entry first-word-fall-through buffer.
//   clk, rst : clock, asynchronous active-high reset (empties the buffer)
//   push/din : write request and data; ignored while full unless a pop
//              happens in the same cycle
//   pop      : consume the head; ignored while empty
//   dout     : head entry, valid whenever empty is 0
//   empty    : no entries held
//   full     : two entries held
module xbar_sync_fifo
  import xbar_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  // A pop in the same cycle frees the slot, so a push on a full buffer
  // is still taken.
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    if (push_ok && !pop_ok)      count_d = count_q + 2'd1;
    else if (!push_ok && pop_ok) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/xbar_master_interface.sv
// Crossbar-side master port: buffers crossbar requests toward an AXI
// slave and buffers the slave's responses back toward the crossbar.
//   ACLK, ARESET               : clock, asynchronous active-high reset
//   AR*/ar_push/ar_full        : read address requests from the crossbar
//   AW*/aw_push/aw_full        : write address requests from the crossbar
//   W*/w_push/w_full           : write data beats from the crossbar
//   R*/r_empty/r_dest_master/r_pop : read data toward the crossbar
//   B*/b_empty/b_dest_master/b_pop : write responses toward the crossbar
//   *_S                        : full AXI AR/R/AW/W/B channels to the slave
// Read and write bursts in flight are each capped at MAX_OUTSTANDING, and
// write data is only released once its address has been accepted.
module xbar_master_interface
  import xbar_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = ID_WIDTH_DEF,
  parameter int unsigned IDS_WIDTH       = IDS_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH       = LEN_WIDTH_DEF,
  parameter int unsigned SIZE_WIDTH      = SIZE_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned STRB_WIDTH      = STRB_WIDTH_DEF,
  parameter int unsigned masters         = MASTERS_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  localparam int unsigned MST_W = (masters > 1) ? $clog2(masters) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // crossbar AR
  input  logic [IDS_WIDTH-1:0]  ARIDS,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [LEN_WIDTH-1:0]  ARLEN,
  input  logic [SIZE_WIDTH-1:0] ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ar_push,
  output logic                  ar_full,
  // crossbar AW
  input  logic [IDS_WIDTH-1:0]  AWIDS,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [LEN_WIDTH-1:0]  AWLEN,
  input  logic [SIZE_WIDTH-1:0] AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  aw_push,
  output logic                  aw_full,
  // crossbar W
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  w_push,
  output logic                  w_full,
  // crossbar R
  output logic [IDS_WIDTH-1:0]  RIDS,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  r_empty,
  output logic [MST_W-1:0]      r_dest_master,
  input  logic                  r_pop,
  // crossbar B
  output logic [IDS_WIDTH-1:0]  BIDS,
  output logic [1:0]            BRESP,
  output logic                  b_empty,
  output logic [MST_W-1:0]      b_dest_master,
  input  logic                  b_pop,
  // slave AR
  output logic [IDS_WIDTH-1:0]  ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [LEN_WIDTH-1:0]  ARLEN_S,
  output logic [SIZE_WIDTH-1:0] ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S,
  // slave R
  input  logic [IDS_WIDTH-1:0]  RID_S,
  input  logic [DATA_WIDTH-1:0] RDATA_S,
  input  logic [1:0]            RRESP_S,
  input  logic                  RLAST_S,
  input  logic                  RVALID_S,
  output logic                  RREADY_S,
  // slave AW
  output logic [IDS_WIDTH-1:0]  AWID_S,
  output logic [ADDR_WIDTH-1:0] AWADDR_S,
  output logic [LEN_WIDTH-1:0]  AWLEN_S,
  output logic [SIZE_WIDTH-1:0] AWSIZE_S,
  output logic [1:0]            AWBURST_S,
  output logic                  AWVALID_S,
  input  logic                  AWREADY_S,
  // slave W
  output logic [DATA_WIDTH-1:0] WDATA_S,
  output logic [STRB_WIDTH-1:0] WSTRB_S,
  output logic                  WLAST_S,
  output logic                  WVALID_S,
  input  logic                  WREADY_S,
  // slave B
  input  logic [IDS_WIDTH-1:0]  BID_S,
  input  logic [1:0]            BRESP_S,
  input  logic                  BVALID_S,
  output logic                  BREADY_S
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AX_W   = IDS_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;
  localparam int unsigned WB_W   = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int unsigned RB_W   = IDS_WIDTH + DATA_WIDTH + 2 + 1;
  localparam int unsigned BB_W   = IDS_WIDTH + 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [AX_W-1:0] ar_dout, aw_dout;
  logic [WB_W-1:0] w_dout;
  logic [RB_W-1:0] r_dout;
  logic [BB_W-1:0] b_dout;
  logic            ar_empty, aw_empty, w_empty;
  logic            r_full, b_full;

  logic [CNT_W-1:0] rd_outstanding_q, rd_outstanding_d;
  logic [CNT_W-1:0] wr_outstanding_q, wr_outstanding_d;
  logic [CNT_W-1:0] w_bursts_q, w_bursts_d;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic r_last_hs, w_last_hs;

  // ---------------- buffers ----------------
  xbar_sync_fifo #(.WIDTH(AX_W)) u_ar_fifo (
    .clk(ACLK), .rst(ARESET), .push(ar_push),
    .din({ARIDS, ARADDR, ARLEN, ARSIZE, ARBURST}),
    .pop(ar_hs), .dout(ar_dout), .empty(ar_empty), .full(ar_full)
  );

  xbar_sync_fifo #(.WIDTH(AX_W)) u_aw_fifo (
    .clk(ACLK), .rst(ARESET), .push(aw_push),
    .din({AWIDS, AWADDR, AWLEN, AWSIZE, AWBURST}),
    .pop(aw_hs), .dout(aw_dout), .empty(aw_empty), .full(aw_full)
  );

  xbar_sync_fifo #(.WIDTH(WB_W)) u_w_fifo (
    .clk(ACLK), .rst(ARESET), .push(w_push),
    .din({WDATA, WSTRB, WLAST}),
    .pop(w_hs), .dout(w_dout), .empty(w_empty), .full(w_full)
  );

  xbar_sync_fifo #(.WIDTH(RB_W)) u_r_fifo (
    .clk(ACLK), .rst(ARESET), .push(r_hs),
    .din({RID_S, RDATA_S, RRESP_S, RLAST_S}),
    .pop(r_pop), .dout(r_dout), .empty(r_empty), .full(r_full)
  );

  xbar_sync_fifo #(.WIDTH(BB_W)) u_b_fifo (
    .clk(ACLK), .rst(ARESET), .push(b_hs),
    .din({BID_S, BRESP_S}),
    .pop(b_pop), .dout(b_dout), .empty(b_empty), .full(b_full)
  );

  // ---------------- slave-side channel control ----------------
  assign {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} = ar_dout;
  assign {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} = aw_dout;
  assign {WDATA_S, WSTRB_S, WLAST_S}                      = w_dout;
  assign {RIDS, RDATA, RRESP, RLAST}                      = r_dout;
  assign {BIDS, BRESP}                                    = b_dout;

  assign ARVALID_S = !ARESET && !ar_empty && (rd_outstanding_q < MAX_CNT);
  // The w_bursts guard keeps the write-data burst counter from wrapping.
  assign AWVALID_S = !ARESET && !aw_empty && (wr_outstanding_q < MAX_CNT)
                     && (w_bursts_q < MAX_CNT);
  // Write data waits until its address has gone out.
  assign WVALID_S  = !ARESET && !w_empty && (w_bursts_q != '0);
  // The buffers come out of reset empty, so readiness is masked while
  // reset is held.
  assign RREADY_S  = !ARESET && !r_full;
  assign BREADY_S  = !ARESET && !b_full;

  assign ar_hs     = ARVALID_S && ARREADY_S;
  assign aw_hs     = AWVALID_S && AWREADY_S;
  assign w_hs      = WVALID_S && WREADY_S;
  assign r_hs      = RVALID_S && RREADY_S;
  assign b_hs      = BVALID_S && BREADY_S;
  assign r_last_hs = r_hs && RLAST_S;
  assign w_last_hs = w_hs && WLAST_S;

  assign r_dest_master = MST_W'(src_master_from_id(64'(RIDS), ID_WIDTH));
  assign b_dest_master = MST_W'(src_master_from_id(64'(BIDS), ID_WIDTH));

  // ---------------- burst counters ----------------
  always_comb begin
    rd_outstanding_d = rd_outstanding_q;
    wr_outstanding_d = wr_outstanding_q;
    w_bursts_d       = w_bursts_q;

    if (ar_hs && !r_last_hs)      rd_outstanding_d = rd_outstanding_q + CNT_W'(1);
    else if (!ar_hs && r_last_hs) rd_outstanding_d = rd_outstanding_q - CNT_W'(1);

    if (aw_hs && !b_hs)           wr_outstanding_d = wr_outstanding_q + CNT_W'(1);
    else if (!aw_hs && b_hs)      wr_outstanding_d = wr_outstanding_q - CNT_W'(1);

    if (aw_hs && !w_last_hs)      w_bursts_d = w_bursts_q + CNT_W'(1);
    else if (!aw_hs && w_last_hs) w_bursts_d = w_bursts_q - CNT_W'(1);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_outstanding_q <= '0;
      wr_outstanding_q <= '0;
      w_bursts_q       <= '0;
    end else begin
      rd_outstanding_q <= rd_outstanding_d;
      wr_outstanding_q <= wr_outstanding_d;
      w_bursts_q       <= w_bursts_d;
    end
  end

endmodule

// File: tb/tb_xbar_master_interface.sv
module tb_xbar_master_interface;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  ARIDS, AWIDS, RIDS, BIDS, ARID_S, AWID_S, RID_S, BID_S;
  logic [31:0] ARADDR, AWADDR, ARADDR_S, AWADDR_S;
  logic [3:0]  ARLEN, AWLEN, ARLEN_S, AWLEN_S;
  logic [2:0]  ARSIZE, AWSIZE, ARSIZE_S, AWSIZE_S;
  logic [1:0]  ARBURST, AWBURST, ARBURST_S, AWBURST_S;
  logic        ar_push, ar_full, aw_push, aw_full, w_push, w_full;
  logic [31:0] WDATA, WDATA_S, RDATA, RDATA_S;
  logic [3:0]  WSTRB, WSTRB_S;
  logic        WLAST, WLAST_S, RLAST, RLAST_S;
  logic [1:0]  RRESP, RRESP_S, BRESP, BRESP_S;
  logic        r_empty, r_pop, b_empty, b_pop;
  logic [0:0]  r_dest_master, b_dest_master;
  logic        ARVALID_S, ARREADY_S, RVALID_S, RREADY_S;
  logic        AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  xbar_master_interface dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARIDS(ARIDS), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ar_push(ar_push), .ar_full(ar_full),
    .AWIDS(AWIDS), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .aw_push(aw_push), .aw_full(aw_full),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .w_push(w_push), .w_full(w_full),
    .RIDS(RIDS), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .r_empty(r_empty),
    .r_dest_master(r_dest_master), .r_pop(r_pop),
    .BIDS(BIDS), .BRESP(BRESP), .b_empty(b_empty), .b_dest_master(b_dest_master), .b_pop(b_pop),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
  );

  typedef struct {
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        exp_dest;
  } rvec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic clear_inputs();
    ARIDS = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ar_push = 0;
    AWIDS = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; aw_push = 0;
    WDATA = '0; WSTRB = 4'hF; WLAST = 0; w_push = 0;
    r_pop = 0; b_pop = 0;
    ARREADY_S = 0; AWREADY_S = 0; WREADY_S = 0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 0; RVALID_S = 0;
    BID_S = '0; BRESP_S = '0; BVALID_S = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESET = 1;
    cyc();
    ARESET = 0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rvec_t vt[6];
    int pushed, hs, beat;
    logic rr;
    logic [31:0] got[$];

    clear_inputs();
    ARESET = 1;
    cyc(); cyc();

    // ---- reset state ----
    chk("rst_arvalid", ARVALID_S, 0);
    chk("rst_awvalid", AWVALID_S, 0);
    chk("rst_wvalid",  WVALID_S, 0);
    chk("rst_rready",  RREADY_S, 0);
    chk("rst_bready",  BREADY_S, 0);
    chk("rst_ar_full", ar_full, 0);
    chk("rst_aw_full", aw_full, 0);
    chk("rst_w_full",  w_full, 0);
    chk("rst_r_empty", r_empty, 1);
    chk("rst_b_empty", b_empty, 1);
    ARESET = 0;
    cyc();

    // ---- single read, 4 beats ----
    ARIDS = 8'h13; ARADDR = 32'h1000_0040; ARLEN = 4'd3; ar_push = 1;
    cyc();
    ar_push = 0;
    chk("rd_arvalid_lat", ARVALID_S, 1);
    chk("rd_arid",   ARID_S, 8'h13);
    chk("rd_araddr", ARADDR_S, 32'h1000_0040);
    chk("rd_arlen",  ARLEN_S, 3);
    ARREADY_S = 1;
    cyc();
    ARREADY_S = 0;
    chk("rd_out_inc", dut.rd_outstanding_q, 1);
    chk("rd_arvalid_done", ARVALID_S, 0);
    for (int b = 0; b < 4; b++) begin
      RVALID_S = 1; RID_S = 8'h13; RDATA_S = 32'hA000 + b; RLAST_S = (b == 3);
      cyc();
      RVALID_S = 0; RLAST_S = 0;
      chk("rd_r_nonempty", r_empty, 0);
      chk("rd_rdata", RDATA, 32'hA000 + b);
      chk("rd_rlast", RLAST, (b == 3) ? 1 : 0);
      chk("rd_dest", r_dest_master, 1);
      r_pop = 1;
      cyc();
      r_pop = 0;
    end
    chk("rd_out_zero", dut.rd_outstanding_q, 0);
    chk("rd_r_empty", r_empty, 1);

    // ---- table-driven return-path vectors ----
    vt[0] = '{8'h00, 32'h0000_0001, 2'd0, 1'b0};
    vt[1] = '{8'h13, 32'hDEAD_BEEF, 2'd1, 1'b1};
    vt[2] = '{8'h2F, 32'h1234_5678, 2'd2, 1'b0};
    vt[3] = '{8'hF0, 32'hFFFF_FFFF, 2'd3, 1'b1};
    vt[4] = '{8'h1A, 32'h0BAD_F00D, 2'd0, 1'b1};
    vt[5] = '{8'hE5, 32'h8000_0000, 2'd2, 1'b0};
    for (int i = 0; i < 6; i++) begin
      RVALID_S = 1; RID_S = vt[i].rid; RDATA_S = vt[i].rdata; RRESP_S = vt[i].rresp; RLAST_S = 0;
      cyc();
      RVALID_S = 0;
      chk("tv_nonempty", r_empty, 0);
      chk("tv_rids",  RIDS, vt[i].rid);
      chk("tv_rdata", RDATA, vt[i].rdata);
      chk("tv_rresp", RRESP, vt[i].rresp);
      chk("tv_dest",  r_dest_master, vt[i].exp_dest);
      r_pop = 1;
      cyc();
      r_pop = 0;
      chk("tv_empty", r_empty, 1);
    end

    // ---- AR buffer: push ignored when full, push+pop on full accepted ----
    do_reset();
    ARLEN = 0;
    ARIDS = 8'hA1; ar_push = 1;
    cyc();
    ARIDS = 8'hA2;
    cyc();
    chk("fifo_full", ar_full, 1);
    ARIDS = 8'hA9;
    cyc();
    chk("fifo_full_hold", ar_full, 1);
    chk("fifo_head_a1", ARID_S, 8'hA1);
    ARIDS = 8'hA3; ARREADY_S = 1;
    cyc();
    ar_push = 0; ARREADY_S = 0;
    chk("fifo_pushpop_full", ar_full, 1);
    chk("fifo_head_a2", ARID_S, 8'hA2);
    ARREADY_S = 1;
    cyc();
    chk("fifo_head_a3", ARID_S, 8'hA3);
    cyc();
    ARREADY_S = 0;
    chk("fifo_drained", ARVALID_S, 0);
    chk("fifo_rd_out", dut.rd_outstanding_q, 3);

    // ---- outstanding read limit ----
    do_reset();
    ARREADY_S = 1; ARLEN = 0;
    pushed = 0; hs = 0;
    for (int c = 0; c < 12; c++) begin
      ar_push = (pushed < 5) && !ar_full;
      ARIDS = 8'h10 + 8'(pushed);
      if (ARVALID_S && ARREADY_S) hs++;
      if (ar_push) pushed++;
      cyc();
    end
    ar_push = 0;
    chk("lim_pushed", pushed, 5);
    chk("lim_hs", hs, 4);
    chk("lim_rd_out", dut.rd_outstanding_q, 4);
    chk("lim_arvalid_held", ARVALID_S, 0);
    RVALID_S = 1; RID_S = 8'h10; RLAST_S = 1;
    cyc();
    RVALID_S = 0; RLAST_S = 0;
    chk("lim_rd_out_dec", dut.rd_outstanding_q, 3);
    chk("lim_arvalid_resume", ARVALID_S, 1);
    chk("lim_arid_5th", ARID_S, 8'h14);
    cyc();
    ARREADY_S = 0;
    chk("lim_rd_out_refill", dut.rd_outstanding_q, 4);
    chk("lim_arvalid_again", ARVALID_S, 0);

    // ---- W gating ----
    do_reset();
    WDATA = 32'hD0; WLAST = 0; w_push = 1;
    cyc();
    WDATA = 32'hD1; WLAST = 1;
    cyc();
    w_push = 0; WLAST = 0;
    chk("w_full", w_full, 1);
    chk("w_gated", WVALID_S, 0);
    WREADY_S = 1;
    cyc();
    chk("w_gated2", WVALID_S, 0);
    chk("w_bursts0", dut.w_bursts_q, 0);
    AWIDS = 8'h15; AWADDR = 32'h2000_0000; AWLEN = 1; aw_push = 1; AWREADY_S = 1;
    cyc();
    aw_push = 0;
    chk("w_awvalid_lat", AWVALID_S, 1);
    chk("w_gated3", WVALID_S, 0);
    cyc();
    AWREADY_S = 0;
    chk("w_bursts1", dut.w_bursts_q, 1);
    chk("w_wr_out1", dut.wr_outstanding_q, 1);
    chk("w_wvalid", WVALID_S, 1);
    chk("w_beat0", WDATA_S, 32'hD0);
    chk("w_last0", WLAST_S, 0);
    cyc();
    chk("w_beat1", WDATA_S, 32'hD1);
    chk("w_last1", WLAST_S, 1);
    cyc();
    WREADY_S = 0;
    chk("w_done_valid", WVALID_S, 0);
    chk("w_bursts_back0", dut.w_bursts_q, 0);
    chk("b_bready", BREADY_S, 1);
    BVALID_S = 1; BID_S = 8'h15; BRESP_S = 2'd2;
    cyc();
    BVALID_S = 0;
    chk("b_nonempty", b_empty, 0);
    chk("b_bids", BIDS, 8'h15);
    chk("b_bresp", BRESP, 2);
    chk("b_dest", b_dest_master, 1);
    chk("b_wr_out0", dut.wr_outstanding_q, 0);
    b_pop = 1;
    cyc();
    b_pop = 0;
    chk("b_empty", b_empty, 1);

    // ---- simultaneous AW and B handshake ----
    do_reset();
    AWREADY_S = 1; AWLEN = 0; aw_push = 1;
    cyc(); cyc();
    aw_push = 0;
    cyc();
    chk("sim_wr_out2", dut.wr_outstanding_q, 2);
    AWREADY_S = 0; aw_push = 1; AWIDS = 8'h07;
    cyc();
    aw_push = 0;
    chk("sim_awvalid", AWVALID_S, 1);
    AWREADY_S = 1; BVALID_S = 1; BID_S = 8'h01;
    cyc();
    AWREADY_S = 0; BVALID_S = 0;
    chk("sim_wr_out_hold", dut.wr_outstanding_q, 2);
    chk("sim_b_nonempty", b_empty, 0);
    chk("sim_w_bursts", dut.w_bursts_q, 3);

    // ---- R backpressure ----
    do_reset();
    ARLEN = 3; ARIDS = 8'h12; ar_push = 1; ARREADY_S = 1;
    cyc();
    ar_push = 0;
    cyc();
    ARREADY_S = 0;
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      RVALID_S = (beat < 4); RID_S = 8'h12; RDATA_S = 32'(beat); RLAST_S = (beat == 3);
      rr = RREADY_S;
      cyc();
      if (rr && beat < 4) beat++;
    end
    chk("bp_beats_taken", beat, 2);
    chk("bp_rready_low", RREADY_S, 0);
    chk("bp_nonempty", r_empty, 0);
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      RVALID_S = (beat < 4); RDATA_S = 32'(beat); RLAST_S = (beat == 3);
      r_pop = !r_empty;
      if (r_pop) got.push_back(RDATA);
      rr = RREADY_S;
      cyc();
      if (rr && beat < 4) beat++;
    end
    RVALID_S = 0; RLAST_S = 0; r_pop = 0;
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp_order", got[i], i);
    end
    chk("bp_rd_out0", dut.rd_outstanding_q, 0);

    // ---- reset mid-burst ----
    do_reset();
    ARLEN = 3; ARIDS = 8'h13; ar_push = 1; ARREADY_S = 1;
    cyc();
    ar_push = 0;
    cyc();
    ARREADY_S = 0;
    RVALID_S = 1; RID_S = 8'h13; RDATA_S = 32'h0;
    ar_push = 1; ARIDS = 8'h14; w_push = 1; WDATA = 32'h55;
    cyc();
    ar_push = 0; w_push = 0;
    RDATA_S = 32'h1;
    chk("mr_arvalid_pre", ARVALID_S, 1);
    #3;
    ARESET = 1;
    #1;
    chk("mr_arvalid", ARVALID_S, 0);
    chk("mr_awvalid", AWVALID_S, 0);
    chk("mr_wvalid",  WVALID_S, 0);
    chk("mr_rready",  RREADY_S, 0);
    chk("mr_r_empty", r_empty, 1);
    chk("mr_ar_full", ar_full, 0);
    chk("mr_rd_out",  dut.rd_outstanding_q, 0);
    chk("mr_w_bursts", dut.w_bursts_q, 0);
    RVALID_S = 0;
    cyc();
    ARESET = 0;
    cyc(); cyc();
    chk("mr_post_arvalid", ARVALID_S, 0);
    chk("mr_post_wvalid",  WVALID_S, 0);
    chk("mr_post_r_empty", r_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
